fg_stream_packer: RTL and testbench
===================================

# fg_stream_packer

Receive-side companion for the registered f/g logic stage: consumes the registered `f` bit stream, with `g` acting as a hold qualifier, and packs sampled bits into WIDTH-bit words. Words are delivered downstream over a valid/ready handshake through a single holding register, with sticky overflow reporting. An optional rising-edge counter on `f` is provided for observation. It sits directly downstream of the f/g register stage in the same clock domain.

## Interface
- WIDTH, 8: bits per packed word (≥2)
- CNT_W, 16: edge counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- f_in  in  1  data bit (upstream registered `f`)
- g_in  in  1  hold: 1 = do not sample f_in this cycle (upstream registered `g`)
- word_out  out  WIDTH  packed word, first sampled bit in bit 0
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  downstream accepts word when high with word_valid
- overflow  out  1  sticky: a completed word was dropped
- clr_ovf  in  1  synchronous clear of overflow
- edge_cnt  out  CNT_W  count of f_in rising edges (see Configuration)

One clock; reset is asynchronous and active-high.

## Operation
- Reset: word_out=0, word_valid=0, overflow=0, edge_cnt=0, shift register=0, bit counter=0, f history=0; output FSM in EMPTY.
- Sampling: each clk edge with g_in=0 shifts f_in into position `bit counter` and increments the counter. g_in=1 leaves the shift register and counter unchanged.
- Completion: the edge that samples bit WIDTH-1 is the completing edge. At that edge the counter wraps to 0 and the shift register clears.
- Output FSM:
  - EMPTY: on a completing edge, load word_out and go to FULL.
  - FULL: word_valid=1. word_out is stable until a transfer (word_valid & word_ready at an edge).
    - Transfer without completion: go to EMPTY.
    - Transfer and completion on the same edge: load the new word and stay FULL; no overflow.
    - Completion without transfer: set overflow, drop the new word, keep the old word.
- overflow: clr_ovf=1 clears it at an edge. If clr_ovf and a new drop occur on the same edge, set wins.
- Reset mid-word discards all partial bits and any held word.

## Timing
- Latency: word_valid rises on the completing edge, so it is visible the cycle after the last bit is presented.
- Minimum completion spacing is WIDTH cycles. With word_ready held at 1, throughput is one word per WIDTH cycles with no drops.
- word_valid never deasserts without a transfer or reset. word_ready may toggle freely.
- overflow rises on the completing edge of the dropped word.
- edge_cnt updates one edge after the f_in 0→1 sample. It is independent of g_in.

## Configuration
- FG_STREAM_PACKER_EDGE_CNT_EN defined:
  - An edge counter increments when f_in=1 and registered previous f_in=0.
  - The counter saturates at 2^CNT_W−1 and resets to 0.
- Not defined: no counter or history logic is built, and edge_cnt is tied to 0. All other behaviour is identical.

## Test plan
- Basic packing (WIDTH=8, g_in=0, word_ready=1): drive f_in = 1,0,1,1,0,0,1,0 → word_out=8'h4D, word_valid high for exactly 1 cycle, overflow=0.
- Hold: same stream with 3 cycles of g_in=1 inserted after bit 3, f_in=1 during those cycles → word_out=8'h4D and word_valid delayed by 3 cycles.
- Backpressure and overflow: word_ready=0; stream 8'h4D then 8'hA5 →
  - word_out stays 8'h4D and word_valid stays 1.
  - overflow=1 at the 2nd completing edge; 8'hA5 is lost.
  - Pulse clr_ovf → overflow=0.
- Simultaneous transfer and completion: word_ready=0 until the 8'hA5 completing edge, then 1 on that edge → word_out=8'hA5, word_valid stays 1, overflow=0.
- Reset mid-word: 5 bits sampled, then assert rst asynchronously between edges → all outputs 0 immediately. The next 8 bits 0xFF produce word_out=8'hFF with no residue.
- Edge counter (macro defined, CNT_W=2): f_in = 0,1,1,0,1,0,1,0,1 → edge_cnt=3 (saturated). Without the macro → edge_cnt=0 throughout.

Source files
------------

// File: rtl/fg_stream_packer.sv
// Packs the registered f stream (g = hold) into WIDTH-bit words behind a one-deep valid/ready holding register.
// Optional f rising-edge counter enabled by FG_STREAM_PACKER_EDGE_CNT_EN; otherwise edge_cnt is tied to 0.
module fg_stream_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in,
  input  logic             g_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] edge_cnt
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] new_word;
  logic             done;
  logic             xfer;

  // new_word is the shift register with the current bit merged in; on a
  // completing edge it is the finished word.
  always_comb begin
    sr_d             = sr_q;
    bcnt_d           = bcnt_q;
    done             = 1'b0;
    new_word         = sr_q;
    new_word[bcnt_q] = f_in;
    if (!g_in) begin
      if (bcnt_q == LAST) begin
        done   = 1'b1;
        sr_d   = '0;
        bcnt_d = '0;
      end else begin
        sr_d   = new_word;
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  assign xfer = (state_q == FULL) && word_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ovf_d   = ovf_q & ~clr_ovf;
    case (state_q)
      EMPTY: begin
        if (done) begin
          word_d  = new_word;
          state_d = FULL;
        end
      end
      FULL: begin
        if (xfer && done) word_d = new_word;
        else if (xfer)    state_d = EMPTY;
        else if (done)    ovf_d = 1'b1; // drop wins over a same-edge clear
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == FULL);
  assign overflow   = ovf_q;

`ifdef FG_STREAM_PACKER_EDGE_CNT_EN
  logic             f_prev_q;
  logic [CNT_W-1:0] ecnt_q;

  // History tracks every edge regardless of g_in; counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_prev_q <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      f_prev_q <= f_in;
      if (f_in && !f_prev_q && (ecnt_q != {CNT_W{1'b1}})) ecnt_q <= ecnt_q + 1'b1;
    end
  end

  assign edge_cnt = ecnt_q;
`else
  assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_fg_stream_packer.sv
// Directed self-checking bench for fg_stream_packer (WIDTH=8, CNT_W=2).
module tb_fg_stream_packer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             f_in = 1'b0;
  logic             g_in = 1'b1;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready = 1'b0;
  logic             overflow;
  logic             clr_ovf = 1'b0;
  logic [CNT_W-1:0] edge_cnt;

  int errors = 0;
  int checks = 0;

  fg_stream_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .f_in(f_in), .g_in(g_in),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .clr_ovf(clr_ovf), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock once, return at the following negedge.
  task automatic cyc(input logic f, input logic g);
    f_in = f;
    g_in = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) cyc(w[i], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g_in = 1'b1;
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word got=%h exp=00", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (edge_cnt !== 2'd0) begin errors++; $display("FAIL reset_ecnt got=%0d exp=0", edge_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    word_ready = 1'b1;
    send_bits(8'h4D, 7);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", word_valid); end
    cyc(1'b0, 1'b0);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", word_valid); end
    checks++; if (word_out !== 8'h4D) begin errors++; $display("FAIL basic_word got=%h exp=4d", word_out); end
    cyc(1'b0, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", word_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_hold();
    word_ready = 1'b1;
    send_bits(8'h4D, 4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL hold_early_valid got=%b exp=0", word_valid); end
    cyc(1'b0, 1'b0);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", word_valid); end
    checks++; if (word_out !== 8'h4D) begin errors++; $display("FAIL hold_word got=%h exp=4d", word_out); end
    cyc(1'b0, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_drop got=%b exp=0", word_valid); end
  endtask

  task automatic test_backpressure();
    word_ready = 1'b0;
    send_bits(8'h4D, 8);
    send_bits(8'hA5, 7);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_early_ovf got=%b exp=0", overflow); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", word_valid); end
    cyc(1'b1, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got=%b exp=1", overflow); end
    checks++; if (word_out !== 8'h4D) begin errors++; $display("FAIL bp_word got=%h exp=4d", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_kept got=%b exp=1", word_valid); end
    cyc(1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got=%b exp=1", overflow); end
    clr_ovf = 1'b1;
    cyc(1'b0, 1'b1);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr got=%b exp=0", overflow); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_after_clr got=%b exp=1", word_valid); end
    word_ready = 1'b1;
    cyc(1'b0, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_simul();
    word_ready = 1'b0;
    send_bits(8'h4D, 8);
    send_bits(8'hA5, 7);
    word_ready = 1'b1;
    cyc(1'b1, 1'b0);
    checks++; if (word_out !== 8'hA5) begin errors++; $display("FAIL simul_word got=%h exp=a5", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got=%b exp=1", word_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got=%b exp=0", overflow); end
    cyc(1'b0, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_reset_mid();
    word_ready = 1'b1;
    send_bits(8'h0D, 5);
    #2 rst = 1'b1;
    #1;
    checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL rstmid_word got=%h exp=00", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", word_valid); end
    checks++; if (edge_cnt !== 2'd0) begin errors++; $display("FAIL rstmid_ecnt got=%0d exp=0", edge_cnt); end
    @(negedge clk);
    rst = 1'b0;
    send_bits(8'hFF, 7);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_residue got=%b exp=0", word_valid); end
    cyc(1'b1, 1'b0);
    checks++; if (word_out !== 8'hFF) begin errors++; $display("FAIL rstmid_word_ff got=%h exp=ff", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid_ff got=%b exp=1", word_valid); end
    cyc(1'b0, 1'b1);
  endtask

  task automatic test_edge_cnt();
    logic [8:0] fs;
    logic [1:0] exp_cnt [9];
    fs = 9'b1_0101_0110; // f_in sequence 0,1,1,0,1,0,1,0,1 from bit 0
    exp_cnt = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(fs[i], 1'b1);
`ifdef FG_STREAM_PACKER_EDGE_CNT_EN
      checks++; if (edge_cnt !== exp_cnt[i]) begin errors++; $display("FAIL ecnt_%0d got=%0d exp=%0d", i, edge_cnt, exp_cnt[i]); end
`else
      checks++; if (edge_cnt !== 2'd0) begin errors++; $display("FAIL ecnt_off_%0d got=%0d exp=0", i, edge_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_backpressure();
    test_simul();
    test_reset_mid();
    test_edge_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
